// File: rtl/sram_addr_counter_if.sv
// AVR-side bus of the SRAM address counter: shift-register load, access strobes and driven address.
// SRAM_ADDR_COUNTER_ACC_COUNT_EN adds the 16-bit completed-access counter.
interface sram_addr_counter_if #(
  parameter int ADDR_W = 21
);
  logic [ADDR_W-1:0] load_addr;
  logic              load_en;
  logic              inc_en;
  logic              ce_n;
  logic              oe_n;
  logic              we_n;
  logic [ADDR_W-1:0] addr_out;
  logic              busy;
  logic              acc_done;
`ifdef SRAM_ADDR_COUNTER_ACC_COUNT_EN
  logic [15:0]       acc_count;

  modport master (
    output load_addr, load_en, inc_en, ce_n, oe_n, we_n,
    input  addr_out, busy, acc_done, acc_count
  );

  modport slave (
    input  load_addr, load_en, inc_en, ce_n, oe_n, we_n,
    output addr_out, busy, acc_done, acc_count
  );
`else
  modport master (
    output load_addr, load_en, inc_en, ce_n, oe_n, we_n,
    input  addr_out, busy, acc_done
  );

  modport slave (
    input  load_addr, load_en, inc_en, ce_n, oe_n, we_n,
    output addr_out, busy, acc_done
  );
`endif
endinterface

// File: rtl/sram_addr_counter.sv
// SRAM address counter: captures the serially loaded address and auto-increments it after each AVR access.
// Define SRAM_ADDR_COUNTER_ACC_COUNT_EN to add the acc_count output (completed accesses since last load).
module sram_addr_counter #(
  parameter int ADDR_W      = 21,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  sram_addr_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic logic [ADDR_W-1:0] addr_wrap_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

  logic [SYNC_STAGES-1:0] ce_n_sync;
  logic [SYNC_STAGES-1:0] oe_n_sync;
  logic [SYNC_STAGES-1:0] we_n_sync;
  logic [SYNC_STAGES-1:0] load_en_sync;
  logic                   ce_n_s, oe_n_s, we_n_s, load_en_s;
  logic                   load_en_q;
  logic                   load_fall;
  logic                   acc;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Strobes idle high, so their synchronizers reset to 1 to avoid a phantom access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ce_n_sync    <= '1;
      oe_n_sync    <= '1;
      we_n_sync    <= '1;
      load_en_sync <= '0;
      load_en_q    <= 1'b0;
    end else begin
      ce_n_sync    <= {ce_n_sync[SYNC_STAGES-2:0], bus.ce_n};
      oe_n_sync    <= {oe_n_sync[SYNC_STAGES-2:0], bus.oe_n};
      we_n_sync    <= {we_n_sync[SYNC_STAGES-2:0], bus.we_n};
      load_en_sync <= {load_en_sync[SYNC_STAGES-2:0], bus.load_en};
      load_en_q    <= load_en_s;
    end
  end

  assign ce_n_s    = ce_n_sync[SYNC_STAGES-1];
  assign oe_n_s    = oe_n_sync[SYNC_STAGES-1];
  assign we_n_s    = we_n_sync[SYNC_STAGES-1];
  assign load_en_s = load_en_sync[SYNC_STAGES-1];
  assign load_fall = load_en_q & ~load_en_s;
  assign acc       = ~ce_n_s & (~oe_n_s | ~we_n_s);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE:    if (acc) state_d = ACTIVE;
      ACTIVE: begin
        if (!acc) begin
          state_d = DONE;
          if (bus.inc_en) addr_d = addr_wrap_inc(addr_q);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Shifting freezes everything; a completed load overrides any access ending on the same edge.
    if (load_en_s) begin
      state_d = IDLE;
      addr_d  = addr_q;
    end else if (load_fall) begin
      state_d = IDLE;
      addr_d  = bus.load_addr;
    end
  end

  assign bus.addr_out = addr_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.acc_done = (state_q == DONE);

`ifdef SRAM_ADDR_COUNTER_ACC_COUNT_EN
  logic [15:0] acc_count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_count_q <= '0;
    end else if (load_fall) begin
      acc_count_q <= '0;
    end else if (state_q == DONE) begin
      acc_count_q <= acc_count_q + 16'd1;
    end
  end

  assign bus.acc_count = acc_count_q;
`endif

endmodule

// File: tb/tb_sram_addr_counter.sv
// Randomized self-checking bench for sram_addr_counter against a transaction-level address model.
module tb_sram_addr_counter;

  localparam int ADDR_W = 21;
  localparam logic [ADDR_W-1:0] ADDR_MASK = '1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  sram_addr_counter_if #(.ADDR_W(ADDR_W)) bus ();

  sram_addr_counter #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  bit busy_seen = 1'b0;

  logic [ADDR_W-1:0] exp_addr;
  int                exp_done;
  logic [15:0]       exp_cnt;

  always @(negedge clk) begin
    if (bus.acc_done === 1'b1) done_cnt++;
    if (bus.busy === 1'b1) busy_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [ADDR_W-1:0] a);
    bus.load_addr = a;
    bus.load_en   = 1'b1;
    idle(4);
    bus.load_en   = 1'b0;
    idle(5);
    exp_addr = a;
    exp_cnt  = 16'd0;
  endtask

  // kind: 0 read, 1 write, 2 both strobes together
  task automatic do_access(input int kind, input int len, input bit inc);
    bus.inc_en = inc;
    bus.ce_n   = 1'b0;
    bus.oe_n   = (kind == 1);
    bus.we_n   = (kind == 0);
    idle(len);
    bus.ce_n = 1'b1;
    bus.oe_n = 1'b1;
    bus.we_n = 1'b1;
    idle(6);
    if (inc) exp_addr = (exp_addr + 1) & ADDR_MASK;
    exp_done++;
    exp_cnt++;
  endtask

  task automatic compare_state(input string tag);
    check({tag, "_addr"}, 32'(bus.addr_out), 32'(exp_addr));
    check({tag, "_done"}, 32'(done_cnt), 32'(exp_done));
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
`ifdef SRAM_ADDR_COUNTER_ACC_COUNT_EN
    check({tag, "_cnt"}, 32'(bus.acc_count), 32'(exp_cnt));
`endif
  endtask

  initial begin
    int base_done;
    logic [ADDR_W-1:0] ra;
    bus.load_addr = '0;
    bus.load_en   = 1'b0;
    bus.inc_en    = 1'b0;
    bus.ce_n      = 1'b1;
    bus.oe_n      = 1'b1;
    bus.we_n      = 1'b1;
    exp_addr = '0;
    exp_done = 0;
    exp_cnt  = 16'd0;

    #1 check("rst_addr", 32'(bus.addr_out), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.acc_done), 32'd0);
    idle(3);
    reset_n = 1'b1;
    idle(3);
    compare_state("idle");

    // Load latency: new address appears on the 3rd rising edge after load_en falls.
    bus.load_addr = 21'h012345;
    bus.load_en   = 1'b1;
    idle(4);
    bus.load_en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 check("load_lat2", 32'(bus.addr_out), 32'd0);
    @(posedge clk);
    #1 check("load_lat3", 32'(bus.addr_out), 32'h012345);
    idle(4);
    exp_addr = 21'h012345;
    compare_state("load");

    // Burst of four reads from 0x0000FE.
    do_load(21'h0000FE);
    for (int i = 0; i < 4; i++) begin
      do_access(0, 4, 1'b1);
      check("burst_addr", 32'(bus.addr_out), 32'h0FF + 32'(i));
    end
    compare_state("burst");

    // Wrap and no-increment at all-ones.
    do_load(21'h1FFFFF);
    do_access(1, 3, 1'b1);
    check("wrap_addr", 32'(bus.addr_out), 32'd0);
    compare_state("wrap");
    do_load(21'h1FFFFF);
    do_access(1, 3, 1'b0);
    check("noinc_addr", 32'(bus.addr_out), 32'h1FFFFF);
    compare_state("noinc");

    // Both strobes low in one access counts once.
    do_access(2, 5, 1'b1);
    compare_state("both");

    // Strobe during shift is ignored.
    base_done = done_cnt;
    bus.load_addr = 21'h0ABCDE;
    bus.load_en   = 1'b1;
    idle(3);
    busy_seen = 1'b0;
    bus.inc_en = 1'b1;
    bus.ce_n = 1'b0;
    bus.oe_n = 1'b0;
    idle(3);
    bus.ce_n = 1'b1;
    bus.oe_n = 1'b1;
    idle(5);
    check("lock_busy", 32'(busy_seen), 32'd0);
    check("lock_done", 32'(done_cnt), 32'(base_done));
    check("lock_addr", 32'(bus.addr_out), 32'(exp_addr));
    bus.load_en = 1'b0;
    idle(5);
    exp_addr = 21'h0ABCDE;
    exp_cnt  = 16'd0;
    compare_state("lock_load");

    // Strobe end coincident with load falling edge: load wins.
    base_done = done_cnt;
    bus.inc_en = 1'b1;
    bus.ce_n = 1'b0;
    bus.oe_n = 1'b0;
    idle(4);
    check("coin_busy", 32'(bus.busy), 32'd1);
    bus.load_addr = 21'h000010;
    bus.load_en   = 1'b1;
    idle(1);
    bus.load_en = 1'b0;
    bus.ce_n = 1'b1;
    bus.oe_n = 1'b1;
    idle(6);
    exp_addr = 21'h000010;
    exp_cnt  = 16'd0;
    check("coin_done", 32'(done_cnt), 32'(base_done));
    compare_state("coin");

`ifdef SRAM_ADDR_COUNTER_ACC_COUNT_EN
    for (int i = 0; i < 5; i++) do_access(i % 3, 2, 1'b1);
    check("cnt5", 32'(bus.acc_count), 32'd5);
    do_load(21'h000123);
    check("cnt_clr", 32'(bus.acc_count), 32'd0);
`endif

    // Randomized mix of loads and accesses.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ra = ADDR_W'($urandom);
        if ($urandom_range(0, 3) == 0) ra = ADDR_MASK - ADDR_W'($urandom_range(0, 2));
        do_load(ra);
      end else begin
        do_access(int'($urandom_range(0, 2)), int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
      end
      idle(int'($urandom_range(0, 3)));
      compare_state("rand");
    end

    // Reset asserted mid-access: immediate return to reset values, no increment.
    do_load(21'h054321);
    bus.inc_en = 1'b1;
    bus.ce_n = 1'b0;
    bus.we_n = 1'b0;
    idle(4);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    base_done = done_cnt;
    #2 reset_n = 1'b0;
    #1 check("mid_rst_addr", 32'(bus.addr_out), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.acc_done), 32'd0);
    bus.ce_n = 1'b1;
    bus.we_n = 1'b1;
    idle(2);
    reset_n = 1'b1;
    idle(6);
    exp_addr = '0;
    exp_cnt  = 16'd0;
    check("post_rst_done", 32'(done_cnt), 32'(base_done));
    check("post_rst_addr", 32'(bus.addr_out), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_addr_counter.md
Name: sram_addr_counter

Overview:
- Sits directly downstream of the serial address shift register and drives the SRAM address pins in its place.
- Captures the parallel address once the AVR finishes a serial load.
- Watches the AVR-driven SRAM strobes and optionally auto-increments the address after each completed access.
- Lets firmware stream bursts of bytes without re-shifting 21 address bits per byte.

Parameters:
- ADDR_W, 21: width of the loaded and driven address.
- SYNC_STAGES, 2: flip-flop stages on each asynchronous AVR input; legal range 2..3.

Ports:
- clk  input  1  free-running CPLD clock; all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- load_addr  input  ADDR_W  parallel address from the shift register, stable while load_en low
- load_en  input  1  shift-register enable from the AVR; high while shifting; falling edge = load complete
- inc_en  input  1  AVR control bit; 1 = auto-increment after each access
- ce_n  input  1  AVR SRAM chip enable, active-low, asynchronous
- oe_n  input  1  AVR SRAM output enable, active-low, asynchronous
- we_n  input  1  AVR SRAM write enable, active-low, asynchronous
- addr_out  output  ADDR_W  address driven to the SRAM
- busy  output  1  high while state is not IDLE
- acc_done  output  1  one-cycle pulse per completed access

Behaviour:
- Reset values:
  - addr_out = 0, busy = 0, acc_done = 0, state = IDLE.
  - Synchronizers for ce_n, oe_n and we_n reset to 1; the load_en synchronizer resets to 0.
  - Reset is effective immediately (asynchronous) and also aborts any access in progress; no increment occurs for that access.
- Synchronization:
  - ce_n, oe_n, we_n and load_en each pass through SYNC_STAGES flops.
  - All decisions below use the synchronized values (_s).
  - load_addr is sampled unsynchronized; it is stable by protocol.
- Load:
  - A falling edge of load_en_s (previous 1, current 0) sets addr_out <= load_addr on that edge and forces state to IDLE.
  - Latency with SYNC_STAGES=2: addr_out takes the new value 3 rising edges after load_en falls at the pin.
- Shift lockout:
  - While load_en_s = 1, state is held in IDLE, no access is detected, and addr_out is frozen.
- Access qualifier: acc = !ce_n_s && (!oe_n_s || !we_n_s).
- FSM:
  - IDLE: go to ACTIVE when acc = 1 and load_en_s = 0.
  - ACTIVE: stay while acc = 1. When acc = 0, go to DONE. On that same edge, if inc_en = 1, addr_out <= addr_out + 1; otherwise addr_out is unchanged.
  - DONE: acc_done = 1 for exactly this cycle, then return to IDLE unconditionally. A new acc seen in DONE is handled from IDLE on the next cycle, with no access lost.
- Arithmetic: the increment is modulo 2^ADDR_W, so all-ones wraps to 0. No carry out and no flag.
- Simultaneous oe_n and we_n low: treated as one access, giving a single increment.
- Simultaneous load falling edge and ACTIVE->DONE transition: the load wins. addr_out = load_addr, there is no increment, state goes to IDLE, and acc_done stays 0.
- inc_en is sampled only on the ACTIVE->DONE edge.
- busy = (state != IDLE).

Optional Feature:
- Macro: SRAM_ADDR_COUNTER_ACC_COUNT_EN.
- With the macro defined:
  - Adds output acc_count (16 bits), reset to 0.
  - acc_count increments (wrapping) on every DONE cycle.
  - acc_count clears to 0 on each load falling edge; a clear coincident with DONE yields 0.
- Without the macro: no port and no counter logic.

Test Plan:
- Reset then idle -> addr_out = 0x000000, busy = 0, acc_done = 0. Assert reset_n low mid-ACTIVE -> immediate return to these values.
- Load 0x012345 (load_en pulse high then low) -> addr_out = 0x012345 on the 3rd clk edge after load_en falls; no acc_done.
- inc_en = 1, four read strobes (ce_n = 0, oe_n low for 4 clk, then high) after loading 0x0000FE -> addr_out sequence 0x0000FF, 0x000100, 0x000101, 0x000102; exactly 4 acc_done pulses.
- inc_en = 1, load 0x1FFFFF, one write strobe -> addr_out = 0x000000 (wrap). Repeat with inc_en = 0 -> addr_out stays 0x1FFFFF, acc_done still pulses.
- Strobe while load_en high -> no busy, no acc_done, addr_out unchanged. Strobe end coincident with load falling edge (load_addr = 0x000010) -> addr_out = 0x000010, no increment, no acc_done.
- With SRAM_ADDR_COUNTER_ACC_COUNT_EN: 5 accesses -> acc_count = 5; then a load -> acc_count = 0.
